mskaes_round_ctrl: RTL and testbench
====================================

// Module: mskaes_round_ctrl
// PURPOSE
//  Round sequencer for the masked 128-bit AES datapath built around the shared 16-sbox DOM SubBytes layer.
//  Accepts one block per in_valid/in_ready handshake, then issues NR rounds through the pipelined SubBytes layer.
//  For each round it waits out the sbox latency and pulses the state-register enable.
//  It also gates the PRNG and key-schedule handshakes, then presents the result via out_valid/out_ready.
//  Control only: no share data passes through this block.
// PARAMETERS
//  SB_LAT   5   SubBytes layer latency in cycles, input register edge to valid output; legal range 2..15
//  NR       10  number of AES rounds; legal range 1..14
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  in_valid    in   1  plaintext shares and round key 0 present on datapath
//  in_ready    out  1  controller can accept a block
//  rk_valid    in   1  round key for round_idx is valid at the key-schedule output
//  rnd_valid   in   1  PRNG drives fresh randomness on rnd_bus0w..3w this cycle
//  rnd_ready   out  1  randomness is consumed by the SubBytes layer this cycle
//  sel_load    out  1  state-register mux selects input block XOR key 0 (initial AddRoundKey)
//  state_en    out  1  state-register write enable
//  last_round  out  1  bypass MixColumns (round_idx==NR)
//  round_idx   out  4  current round number, 0..NR; also the key-schedule index
//  busy        out  1  block in flight (LOAD/ROUND/DONE)
//  out_valid   out  1  state register holds the ciphertext shares
//  out_ready   in   1  consumer accepts the ciphertext
// BEHAVIOUR
//  Reset values (async): fsm=IDLE, lat_cnt=0, round_idx=0.
//   in_ready=1; rnd_ready, sel_load, state_en, last_round, busy and out_valid are all 0.
//  FSM states: IDLE, ROUND, DONE. Encodings live in design.vh.
//  IDLE: in_ready=1.
//   On in_valid: sel_load=1 and state_en=1 (same cycle), round_idx<=1, lat_cnt<=0, next state ROUND.
//  ROUND: rnd_ready=1 every cycle; lat_cnt counts 0..SB_LAT-1.
//   state_en=1 only when lat_cnt==SB_LAT-1 && rk_valid && rnd_valid.
//   On that cycle: lat_cnt<=0. If round_idx==NR go to DONE, else round_idx<=round_idx+1.
//  Key stall: lat_cnt==SB_LAT-1 && !rk_valid holds lat_cnt and round_idx (no state_en).
//   The sbox inputs stay stable during the stall, so the output stays correct.
//  Randomness drop: rnd_valid=0 in any ROUND cycle sets lat_cnt<=0. The in-flight round restarts and the data is discarded.
//   A drop at lat_cnt==k costs k+1 extra cycles.
//   A simultaneous key stall and randomness drop is treated as a drop.
//  last_round = (fsm==ROUND && round_idx==NR), combinational from registered state.
//  DONE: out_valid=1, held with no state_en until out_ready.
//   On out_ready: round_idx<=0, next state IDLE. in_ready is 0 in DONE (no overlap with the next block).
//  in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
//  Nominal latency, all valids high: handshake cycle + NR*SB_LAT cycles.
//   With defaults: out_valid first high 51 cycles after the accept edge. 11 state_en pulses per block.
//  rst asserted mid-operation: immediate return to reset values; the partial block is dropped.
//  Widths: lat_cnt is 4 bits, round_idx is 4 bits; no wrap is possible within the legal parameter ranges.
// STRUCTURE
//  Shared constants in design.vh: FSM encodings, default NR/SB_LAT, round_idx width.
//  One sub-module: mskaes_sb_lat_cnt.
//   Ports: clear, hold, and a terminal flag at SB_LAT-1.
//   Reused by any future SubBytes-layer client.
//  Everything else is a single always block (async rst) plus combinational output decode.
// TESTING
//  T1 nominal: rk_valid=rnd_valid=out_ready=1, in_valid pulse at c0.
//   -> state_en at c0 and then every 5 cycles.
//   -> last_round only with round_idx=10; out_valid at c51 for 1 cycle; in_ready back at c52.
//  T2 key stall: rk_valid=0 for 3 cycles starting at the terminal cycle of round 4.
//   -> round_idx holds at 4; out_valid delayed to c54.
//  T3 randomness drop: rnd_valid=0 for one cycle at round 2, lat_cnt=2.
//   -> lat_cnt restarts at 0; no state_en for round 2 until 5 clean cycles; out_valid at c54.
//  T4 backpressure: out_ready=0 for 4 cycles after out_valid rises.
//   -> out_valid held 5 cycles, state_en=0; in_valid ignored meanwhile.
//  T5 reset mid-round: rst high at round 6.
//   -> all outputs at reset values the same cycle; a new block after release completes in 51 cycles.
//  T6 parameters: SB_LAT=2, NR=14 -> out_valid 29 cycles after accept, 15 state_en pulses.

Source files
------------

// File: rtl/mskaes_round_ctrl_pkg.sv
// rtl/mskaes_round_ctrl_pkg.sv - shared constants and FSM encoding for the masked AES round sequencer
package mskaes_round_ctrl_pkg;

   localparam int NR_DEF     = 10;
   localparam int SB_LAT_DEF = 5;
   localparam int RIDX_W     = 4;
   localparam int LAT_W      = 4;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_ROUND = 2'd1,
      FSM_DONE  = 2'd2
   } fsm_t;

endpackage

// File: rtl/mskaes_sb_lat_cnt.sv
// rtl/mskaes_sb_lat_cnt.sv - SubBytes-layer latency counter with clear/hold and terminal flag
module mskaes_sb_lat_cnt
   import mskaes_round_ctrl_pkg::*;
#(
   parameter int SB_LAT = SB_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic hold,
   output logic terminal
);

   logic [LAT_W-1:0] cnt;

   // clear wins over hold so a randomness drop during a key stall restarts the round
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign terminal = (cnt == LAT_W'(SB_LAT - 1));

endmodule

// File: rtl/mskaes_round_ctrl.sv
// rtl/mskaes_round_ctrl.sv - round sequencer for the masked 128-bit AES DOM SubBytes datapath
module mskaes_round_ctrl
   import mskaes_round_ctrl_pkg::*;
#(
   parameter int SB_LAT = SB_LAT_DEF,
   parameter int NR     = NR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              rk_valid,
   input  logic              rnd_valid,
   output logic              rnd_ready,
   output logic              sel_load,
   output logic              state_en,
   output logic              last_round,
   output logic [RIDX_W-1:0] round_idx,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready
);

   fsm_t fsm;
   fsm_t fsm_nxt;
   logic lat_term;
   logic in_round;
   logic round_go;
   logic at_last;
   logic lat_clear;
   logic lat_hold;

   assign in_round = (fsm == FSM_ROUND);
   assign at_last  = (round_idx == RIDX_W'(NR));
   assign round_go = in_round && lat_term && rk_valid && rnd_valid;

   // the sbox inputs stay stable across a key stall, so holding the count is safe
   assign lat_clear = !in_round || !rnd_valid || (lat_term && rk_valid);
   assign lat_hold  = lat_term && !rk_valid;

   mskaes_sb_lat_cnt #(
      .SB_LAT (SB_LAT)
   ) u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (lat_clear),
      .hold     (lat_hold),
      .terminal (lat_term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= FSM_IDLE;
         round_idx <= '0;
      end else begin
         fsm <= fsm_nxt;
         case (fsm)
            FSM_IDLE:  if (in_valid) round_idx <= RIDX_W'(1);
            FSM_ROUND: if (round_go && !at_last) round_idx <= round_idx + 1'b1;
            FSM_DONE:  if (out_ready) round_idx <= '0;
            default:   round_idx <= '0;
         endcase
      end
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         FSM_IDLE:  if (in_valid) fsm_nxt = FSM_ROUND;
         FSM_ROUND: if (round_go && at_last) fsm_nxt = FSM_DONE;
         FSM_DONE:  if (out_ready) fsm_nxt = FSM_IDLE;
         default:   fsm_nxt = FSM_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      rnd_ready  = 1'b0;
      sel_load   = 1'b0;
      state_en   = 1'b0;
      last_round = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      case (fsm)
         FSM_IDLE: begin
            in_ready = 1'b1;
            sel_load = in_valid;
            state_en = in_valid;
         end
         FSM_ROUND: begin
            rnd_ready  = 1'b1;
            state_en   = round_go;
            last_round = at_last;
            busy       = 1'b1;
         end
         FSM_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mskaes_round_ctrl.sv
// tb/tb_mskaes_round_ctrl.sv - directed table-driven bench for the masked AES round sequencer
module tb_mskaes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, rk_valid, rnd_valid, rnd_ready;
   logic       sel_load, state_en, last_round, busy, out_valid, out_ready;
   logic [3:0] round_idx;

   logic       in_valid_b, in_ready_b, rnd_ready_b, sel_load_b, state_en_b;
   logic       last_round_b, busy_b, out_valid_b;
   logic [3:0] round_idx_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mskaes_round_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rk_valid   (rk_valid),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .sel_load   (sel_load),
      .state_en   (state_en),
      .last_round (last_round),
      .round_idx  (round_idx),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   mskaes_round_ctrl #(.SB_LAT(2), .NR(14)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_b),
      .in_ready   (in_ready_b),
      .rk_valid   (1'b1),
      .rnd_valid  (1'b1),
      .rnd_ready  (rnd_ready_b),
      .sel_load   (sel_load_b),
      .state_en   (state_en_b),
      .last_round (last_round_b),
      .round_idx  (round_idx_b),
      .busy       (busy_b),
      .out_valid  (out_valid_b),
      .out_ready  (1'b1)
   );

   typedef struct {
      string name;
      int    ks;
      int    kl;
      int    drop;
      int    bp;
      int    iv_extra;
      int    probe;
      int    exp_ridx;
      int    exp_ov;
      int    exp_len;
      int    exp_pulses;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // called at a negedge with the DUT idle; cycle c0 is the accept cycle
   task automatic run_vec(input vec_t v);
      int first_ov = -1;
      int ov_len = 0;
      int pulses = 0;
      int lr_cnt = 0;
      int lr_bad = 0;
      int probe_ridx = -1;
      int probe_busy = -1;
      int probe_rr = -1;
      int last;
      last = v.exp_ov + v.exp_len + 2;
      #2;
      check({v.name, ".in_ready_pre"}, in_ready, 1);
      @(negedge clk);
      for (int c = 0; c <= last; c++) begin
         in_valid  = (c == 0) || (c == v.iv_extra);
         rk_valid  = !(c >= v.ks && c < v.ks + v.kl);
         rnd_valid = (c != v.drop);
         out_ready = (ov_len >= v.bp);
         #2;
         if (c == 0) begin
            check({v.name, ".sel_load_c0"}, sel_load, 1);
            check({v.name, ".state_en_c0"}, state_en, 1);
         end
         if (state_en) pulses++;
         if (out_valid) begin
            if (first_ov < 0) first_ov = c;
            ov_len++;
         end
         if (last_round) begin
            lr_cnt++;
            if (round_idx != 4'd10) lr_bad++;
         end
         if (c == v.probe) begin
            probe_ridx = round_idx;
            probe_busy = busy;
            probe_rr   = rnd_ready;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      rk_valid  = 1'b1;
      rnd_valid = 1'b1;
      out_ready = 1'b1;
      #2;
      check({v.name, ".first_out_valid"}, first_ov, v.exp_ov);
      check({v.name, ".out_valid_len"}, ov_len, v.exp_len);
      check({v.name, ".state_en_pulses"}, pulses, v.exp_pulses);
      check({v.name, ".last_round_cycles"}, lr_cnt, 5);
      check({v.name, ".last_round_bad_idx"}, lr_bad, 0);
      check({v.name, ".probe_round_idx"}, probe_ridx, v.exp_ridx);
      check({v.name, ".probe_busy"}, probe_busy, 1);
      check({v.name, ".probe_rnd_ready"}, probe_rr, 1);
      check({v.name, ".in_ready_post"}, in_ready, 1);
      check({v.name, ".round_idx_post"}, round_idx, 0);
      @(negedge clk);
   endtask

   initial begin
      int first_ov;
      int pulses;
      int lr_cnt;

      //         name             ks  kl drop bp  ivx probe ridx ov len pulses
      vecs[0] = '{"nominal",      -1, 0, -1,  0, -1,  25,  5,  51, 1, 11};
      vecs[1] = '{"key_stall",    20, 3, -1,  0, -1,  22,  4,  54, 1, 11};
      vecs[2] = '{"rnd_drop",     -1, 0,  8,  0, -1,  13,  2,  54, 1, 11};
      vecs[3] = '{"backpressure", -1, 0, -1,  4, 53,  40,  8,  51, 5, 11};
      vecs[4] = '{"stall_drop",   20, 1, 20,  0, -1,  22,  4,  56, 1, 11};
      vecs[5] = '{"drop_lat0",    -1, 0,  6,  0, -1,  11,  2,  52, 1, 11};

      rst        = 1'b1;
      in_valid   = 1'b0;
      rk_valid   = 1'b1;
      rnd_valid  = 1'b1;
      out_ready  = 1'b1;
      in_valid_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      check("reset.in_ready", in_ready, 1);
      check("reset.rnd_ready", rnd_ready, 0);
      check("reset.sel_load", sel_load, 0);
      check("reset.state_en", state_en, 0);
      check("reset.last_round", last_round, 0);
      check("reset.round_idx", round_idx, 0);
      check("reset.busy", busy, 0);
      check("reset.out_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // reset in round 6 (cycles 26..30), then a fresh block must run nominally
      for (int c = 0; c <= 28; c++) begin
         in_valid = (c == 0);
         if (c < 28) @(negedge clk);
      end
      #2;
      check("midreset.busy_before", busy, 1);
      check("midreset.round_idx_before", round_idx, 6);
      rst = 1'b1;
      #1;
      check("midreset.in_ready", in_ready, 1);
      check("midreset.rnd_ready", rnd_ready, 0);
      check("midreset.busy", busy, 0);
      check("midreset.round_idx", round_idx, 0);
      check("midreset.state_en", state_en, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(vecs[0]);

      // SB_LAT=2, NR=14 instance
      first_ov = -1;
      pulses   = 0;
      lr_cnt   = 0;
      for (int c = 0; c <= 34; c++) begin
         in_valid_b = (c == 0);
         #2;
         if (state_en_b) pulses++;
         if (last_round_b) lr_cnt++;
         if (out_valid_b && first_ov < 0) first_ov = c;
         @(negedge clk);
      end
      in_valid_b = 1'b0;
      check("params.first_out_valid", first_ov, 29);
      check("params.state_en_pulses", pulses, 15);
      check("params.last_round_cycles", lr_cnt, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
